// File: rtl/lfsr_rng_if.sv
// lfsr_rng_if: request/seed/result bundle between a random-value consumer and lfsr_rng_multi.
interface lfsr_rng_if #(parameter int OUT_W = 32);
  logic              req;
  logic              seed_load;
  logic [3:0]        seed_lane;
  logic [31:0]       seed_data;
  logic              busy;
  logic              rand_valid;
  logic [OUT_W-1:0]  rand_out;
  logic              forced_zero;
  modport master(output req, seed_load, seed_lane, seed_data, input busy, rand_valid, rand_out, forced_zero);
  modport slave(input req, seed_load, seed_lane, seed_data, output busy, rand_valid, rand_out, forced_zero);
endinterface

// File: rtl/lfsr_rng_multi.sv
// lfsr_rng_multi: LANES Fibonacci LFSRs form a signed sample; the most-negative code is redrawn.
// Optional LFSR_FREERUN_EN: lanes step every clock instead of only while generating.
module lfsr_rng_multi #(
  parameter int LANES     = 4,
  parameter int OUT_W     = 32,
  parameter int RETRY_MAX = 7
) (
  input logic       clock,
  input logic       reset,
  lfsr_rng_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GEN  = 1'b1;
  localparam logic [LANES-1:0] REJECT = {1'b1, {(LANES-1){1'b0}}};
  logic [0:0]       state;
  logic [3:0]       retry;
  logic [31:0]      lane [LANES];
  logic [31:0]      stepped [LANES];
  logic [LANES-1:0] cand;
  function automatic logic [31:0] default_seed(input int i);
    return 32'hACE1ACE1 ^ (32'(i) * 32'h9E3779B9);
  endfunction
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      stepped[i] = {lane[i][30:0], lane[i][31] ^ lane[i][21] ^ lane[i][1] ^ lane[i][0]};
      cand[i]    = stepped[i][0];
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      retry           <= '0;
      bus.busy        <= 1'b0;
      bus.rand_valid  <= 1'b0;
      bus.rand_out    <= '0;
      bus.forced_zero <= 1'b0;
      for (int i = 0; i < LANES; i++) lane[i] <= default_seed(i);
    end else if (state == IDLE) begin
      bus.rand_valid <= 1'b0;
`ifdef LFSR_FREERUN_EN
      for (int i = 0; i < LANES; i++) lane[i] <= stepped[i];
`else
`endif
      // a zero seed would lock the LFSR at zero, so it selects the lane default instead
      for (int i = 0; i < LANES; i++)
        if (bus.seed_load && bus.seed_lane == 4'(i))
          lane[i] <= (bus.seed_data == '0) ? default_seed(i) : bus.seed_data;
      if (bus.req) begin
        state    <= GEN;
        bus.busy <= 1'b1;
        retry    <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) lane[i] <= stepped[i];
      if (cand != REJECT) begin
        bus.rand_out    <= OUT_W'($signed(cand));
        bus.rand_valid  <= 1'b1;
        bus.forced_zero <= 1'b0;
        bus.busy        <= 1'b0;
        state           <= IDLE;
      end else if (retry == 4'(RETRY_MAX - 1)) begin
        bus.rand_out    <= '0;
        bus.rand_valid  <= 1'b1;
        bus.forced_zero <= 1'b1;
        bus.busy        <= 1'b0;
        state           <= IDLE;
      end else begin
        retry <= retry + 4'd1;
      end
    end
  end
endmodule
